cpu_multicycle_ctrl: RTL and testbench

- Multi-cycle control unit that owns the program counter and sequences the 4-bit datapath: 16x8 instruction ROM, 4x4 register file, 4-bit ALU and 16x4 data memory.
- Fetches 8-bit instructions, decodes them, and issues register-file, ALU and data-memory controls one state at a time, honouring the one-cycle registered read latency of the register file and data memory.
- Replaces the free-running program counter at the top level.

---
 rtl/cpu_multicycle_ctrl_if.sv | 43 ++++
 rtl/cpu_multicycle_ctrl.sv | 139 +++++++++++++
 tb/tb_cpu_multicycle_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_multicycle_ctrl_if.sv
// Bundle of the controller <-> datapath signals: instruction ROM, register
// file, ALU, data memory, plus the start/status lines seen by the top level.
// The controller connects via the master modport, the datapath via slave.
interface cpu_multicycle_ctrl_if #(
  parameter int PC_W  = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic [PC_W-1:0]  imem_addr;
  logic [7:0]       imem_data;
  logic             rf_rw;
  logic [1:0]       rf_rd1;
  logic [1:0]       rf_rd2;
  logic [1:0]       rf_wr;
  logic [3:0]       rf_wdata;
  logic [3:0]       rf_q1;
  logic [3:0]       rf_q2;
  logic [1:0]       alu_op;
  logic             alu_binv;
  logic             alu_cin;
  logic [3:0]       alu_res;
  logic             dm_rw;
  logic [3:0]       dm_addr;
  logic [3:0]       dm_wdata;
  logic [3:0]       dm_rdata;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, imem_data, rf_q1, rf_q2, alu_res, dm_rdata,
    output imem_addr, rf_rw, rf_rd1, rf_rd2, rf_wr, rf_wdata,
           alu_op, alu_binv, alu_cin, dm_rw, dm_addr, dm_wdata,
           busy, halted, retired
  );

  modport slave (
    output start, imem_data, rf_q1, rf_q2, alu_res, dm_rdata,
    input  imem_addr, rf_rw, rf_rd1, rf_rd2, rf_wr, rf_wdata,
           alu_op, alu_binv, alu_cin, dm_rw, dm_addr, dm_wdata,
           busy, halted, retired
  );
endinterface

// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle control unit for the 4-bit CPU. Owns the program counter,
// fetches 8-bit instructions and sequences register file, ALU and data
// memory one state at a time. The register file and data memory have a
// one-cycle registered read, so operands are requested one state before use.
module cpu_multicycle_ctrl #(
  parameter int PC_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_multicycle_ctrl_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEMRD  = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] HALT   = 3'd6;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  logic [2:0]       state;
  logic [PC_W-1:0]  pc;
  logic [7:0]       ir;
  logic [3:0]       wb_data;
  logic [CNT_W-1:0] retired;

  logic [2:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       unused_ir0;

  assign op         = ir[7:5];
  assign rd         = ir[4:3];
  assign rs         = ir[2:1];
  assign unused_ir0 = ir[0];

  // Sequencer: state transitions plus pc / ir / wb_data / retired updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      wb_data <= '0;
      retired <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) state <= FETCH;
        end
        FETCH: begin
          ir    <= bus.imem_data;
          state <= DECODE;
        end
        DECODE: begin
          // Register reads issued here land on rf_q1/rf_q2 for EXEC.
          state <= (op == OP_HALT) ? HALT : EXEC;
        end
        EXEC: begin
          case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: begin
              wb_data <= bus.alu_res;
              state   <= WB;
            end
            OP_LW: state <= MEMRD;
            OP_SW: begin
              // Store commits on this edge, nothing left to write back.
              pc      <= pc + 1'b1;
              retired <= retired + 1'b1;
              state   <= FETCH;
            end
            default: state <= HALT;
          endcase
        end
        MEMRD: begin
          wb_data <= bus.dm_rdata;
          state   <= WB;
        end
        WB: begin
          pc      <= pc + 1'b1;
          retired <= retired + 1'b1;
          state   <= FETCH;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath controls decoded from the registered state and instruction;
  // write strobes are suppressed whenever rst is high.
  always_comb begin
    bus.rf_rw    = 1'b1;
    bus.dm_rw    = 1'b1;
    bus.alu_op   = 2'd0;
    bus.alu_binv = 1'b0;
    bus.alu_cin  = 1'b0;
    if (state == WB && !rst) bus.rf_rw = 1'b0;
    if (state == EXEC && op == OP_SW && !rst) bus.dm_rw = 1'b0;
    if (state == EXEC) begin
      case (op)
        OP_OR:  bus.alu_op = 2'd1;
        OP_ADD: bus.alu_op = 2'd2;
        OP_SUB: begin
          bus.alu_binv = 1'b1;
          bus.alu_cin  = 1'b1;
          bus.alu_op   = 2'd2;
        end
        OP_SLT: begin
          bus.alu_binv = 1'b1;
          bus.alu_cin  = 1'b1;
          bus.alu_op   = 2'd3;
        end
        default: bus.alu_op = 2'd0;
      endcase
    end
  end

  assign bus.imem_addr = pc;
  assign bus.rf_rd1    = rd;
  assign bus.rf_rd2    = rs;
  assign bus.rf_wr     = rd;
  assign bus.rf_wdata  = wb_data;
  assign bus.dm_addr   = bus.rf_q2;
  assign bus.dm_wdata  = bus.rf_q1;
  assign bus.busy      = (state != IDLE) && (state != HALT);
  assign bus.halted    = (state == HALT);
  assign bus.retired   = retired;

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Bench for cpu_multicycle_ctrl: ROM, register file, ALU and data memory
// models around the controller; expected writes go into a scoreboard queue
// and a negedge monitor pops them whenever a write strobe is seen.
module tb_cpu_multicycle_ctrl;
  localparam int PC_W  = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  typedef struct {
    logic       dm;
    logic [3:0] addr;
    logic [3:0] data;
    int         cyc;
  } wr_t;

  wr_t        exp_q[$];
  logic [3:0] alu_log[$];

  logic [7:0] rom[16];
  logic [3:0] rf[4];
  logic [3:0] rf_init[4];
  logic [3:0] dmem[16];
  logic [3:0] dm_init[16];
  logic [3:0] alu_b;

  cpu_multicycle_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  cpu_multicycle_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction ROM: combinational read.
  assign bus.imem_data = rom[bus.imem_addr];

  // Register file: registered read, write when rf_rw = 0, reloaded on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= rf_init[i];
      bus.rf_q1 <= 4'h0;
      bus.rf_q2 <= 4'h0;
    end else if (!bus.rf_rw) begin
      rf[bus.rf_wr] <= bus.rf_wdata;
    end else begin
      bus.rf_q1 <= rf[bus.rf_rd1];
      bus.rf_q2 <= rf[bus.rf_rd2];
    end
  end

  // Data memory: registered read, write when dm_rw = 0, reloaded on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) dmem[i] <= dm_init[i];
      bus.dm_rdata <= 4'h0;
    end else if (!bus.dm_rw) begin
      dmem[bus.dm_addr] <= bus.dm_wdata;
    end else begin
      bus.dm_rdata <= dmem[bus.dm_addr];
    end
  end

  // ALU model: AND/OR/ADD/SLT with optional inverted b and carry-in.
  assign alu_b = bus.alu_binv ? ~bus.rf_q2 : bus.rf_q2;
  always_comb begin
    bus.alu_res = 4'h0;
    case (bus.alu_op)
      2'd0: bus.alu_res = bus.rf_q1 & alu_b;
      2'd1: bus.alu_res = bus.rf_q1 | alu_b;
      2'd2: bus.alu_res = bus.rf_q1 + alu_b + {3'b000, bus.alu_cin};
      default: bus.alu_res = {3'b000, ($signed(bus.rf_q1) < $signed(bus.rf_q2))};
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_write(input logic dm, input logic [3:0] addr, input logic [3:0] data);
    wr_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_write: dm=%0d addr=%0d data=%0d at cycle %0d, required none",
               dm, addr, data, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("wr_kind", {31'd0, dm}, {31'd0, e.dm});
      chk("wr_addr", {28'd0, addr}, {28'd0, e.addr});
      chk("wr_data", {28'd0, data}, {28'd0, e.data});
      if (e.cyc >= 0) chk("wr_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: log non-default ALU controls and score every write strobe.
  always @(negedge clk) begin
    if (bus.alu_binv || bus.alu_cin || bus.alu_op != 2'd0)
      alu_log.push_back({bus.alu_binv, bus.alu_cin, bus.alu_op});
    if (bus.rf_rw === 1'b0) begin
      chk("write_excl", {31'd0, bus.dm_rw}, 32'd1);
      check_write(1'b0, {2'b00, bus.rf_wr}, bus.rf_wdata);
    end
    if (bus.dm_rw === 1'b0) check_write(1'b1, bus.dm_addr, bus.dm_wdata);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_rf_rw", {31'd0, bus.rf_rw}, 32'd1);
    chk("rst_dm_rw", {31'd0, bus.dm_rw}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_pc", {28'd0, bus.imem_addr}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_retired", {24'd0, bus.retired}, 32'd0);
  endtask

  task automatic start_prog(output int t0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_pc(input int target, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.imem_addr == target[PC_W-1:0]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_total++;
      $display("FAIL wait_pc: pc=%0d, required %0d within %0d cycles", bus.imem_addr, target, budget);
    end
  endtask

  task automatic wait_halt(input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.halted) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      n_total++;
      $display("FAIL wait_halt: halted=%0d, required 1 within %0d cycles", bus.halted, budget);
    end
  endtask

  task automatic wait_retired(input int n, input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.retired == n[CNT_W-1:0]) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      n_total++;
      $display("FAIL wait_retired: retired=%0d, required %0d within %0d cycles", bus.retired, n, budget);
    end
  endtask

  task automatic setup(input logic [3:0] r0, input logic [3:0] r1,
                       input logic [3:0] r2, input logic [3:0] r3, input logic [7:0] fill);
    for (int i = 0; i < 16; i++) begin
      rom[i] = fill;
      dm_init[i] = 4'h0;
    end
    rf_init[0] = r0;
    rf_init[1] = r1;
    rf_init[2] = r2;
    rf_init[3] = r3;
  endtask

  initial begin
    int t0;
    int at;
    int at2;
    bus.start = 1'b0;
    setup(4'h0, 4'h0, 4'h0, 4'h0, 8'hFF);

    // Reset and idle hold
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_pc", {28'd0, bus.imem_addr}, 32'd0);
    chk("idle_retired", {24'd0, bus.retired}, 32'd0);

    // ADD r1,r2 : 5 + 3 = 8
    setup(4'h0, 4'h5, 4'h3, 4'h0, 8'hFF);
    rom[0] = 8'b010_01_10_0;
    do_reset();
    alu_log.delete();
    start_prog(t0);
    exp_q.push_back('{1'b0, 4'd1, 4'd8, t0 + 3});
    wait_pc(1, 20, at);
    chk("add_latency", at - t0, 32'd4);
    wait_halt(20);
    chk("add_alu_n", alu_log.size(), 32'd1);
    if (alu_log.size() > 0) chk("add_alu_ctrl", {28'd0, alu_log[0]}, 32'b0010);
    chk("add_retired", {24'd0, bus.retired}, 32'd1);
    chk("add_pc", {28'd0, bus.imem_addr}, 32'd1);
    chk("add_busy_halt", {31'd0, bus.busy}, 32'd0);
    chk("add_r1", {28'd0, rf[1]}, 32'd8);
    chk("add_sb_drained", exp_q.size(), 32'd0);

    // SUB r1,r2 then SLT r1,r2
    setup(4'h0, 4'h5, 4'h6, 4'h0, 8'hFF);
    rom[0] = 8'b011_01_10_0;
    rom[1] = 8'b100_01_10_0;
    do_reset();
    alu_log.delete();
    start_prog(t0);
    exp_q.push_back('{1'b0, 4'd1, 4'd15, t0 + 3});
    exp_q.push_back('{1'b0, 4'd1, 4'd1, t0 + 7});
    wait_halt(30);
    chk("subslt_alu_n", alu_log.size(), 32'd2);
    if (alu_log.size() > 1) begin
      chk("sub_alu_ctrl", {28'd0, alu_log[0]}, 32'b1110);
      chk("slt_alu_ctrl", {28'd0, alu_log[1]}, 32'b1111);
    end
    chk("slt_r1", {28'd0, rf[1]}, 32'd1);
    chk("subslt_retired", {24'd0, bus.retired}, 32'd2);
    chk("subslt_sb_drained", exp_q.size(), 32'd0);

    // SW r3,r0 then LW r2,r0
    setup(4'h4, 4'h0, 4'h0, 4'h9, 8'hFF);
    rom[0] = 8'b110_11_00_0;
    rom[1] = 8'b101_10_00_0;
    do_reset();
    start_prog(t0);
    exp_q.push_back('{1'b1, 4'd4, 4'd9, t0 + 2});
    exp_q.push_back('{1'b0, 4'd2, 4'd9, t0 + 7});
    wait_pc(1, 20, at);
    chk("sw_latency", at - t0, 32'd3);
    wait_pc(2, 20, at2);
    chk("lw_latency", at2 - at, 32'd5);
    wait_halt(20);
    chk("mem_retired", {24'd0, bus.retired}, 32'd2);
    chk("mem_dmem4", {28'd0, dmem[4]}, 32'd9);
    chk("mem_r2", {28'd0, rf[2]}, 32'd9);
    chk("mem_sb_drained", exp_q.size(), 32'd0);

    // 15 x AND r0,r0 then HALT at address 15
    setup(4'hA, 4'h0, 4'h0, 4'h0, 8'h00);
    rom[15] = 8'hFF;
    do_reset();
    start_prog(t0);
    for (int i = 0; i < 15; i++) exp_q.push_back('{1'b0, 4'd0, 4'hA, -1});
    wait_halt(200);
    chk("halt_retired", {24'd0, bus.retired}, 32'd15);
    chk("halt_pc", {28'd0, bus.imem_addr}, 32'd15);
    repeat (10) @(posedge clk);
    #1;
    chk("halt_hold_pc", {28'd0, bus.imem_addr}, 32'd15);
    chk("halt_hold_retired", {24'd0, bus.retired}, 32'd15);
    chk("halt_hold_halted", {31'd0, bus.halted}, 32'd1);
    chk("halt_sb_drained", exp_q.size(), 32'd0);

    // PC wrap: 16 non-HALT instructions, then one more from address 0
    setup(4'h6, 4'h0, 4'h0, 4'h0, 8'h00);
    do_reset();
    start_prog(t0);
    for (int i = 0; i < 17; i++) exp_q.push_back('{1'b0, 4'd0, 4'h6, -1});
    wait_retired(16, 200);
    chk("wrap_pc", {28'd0, bus.imem_addr}, 32'd0);
    chk("wrap_busy", {31'd0, bus.busy}, 32'd1);
    rom[1] = 8'hFF;
    wait_halt(50);
    chk("wrap_retired", {24'd0, bus.retired}, 32'd17);
    chk("wrap_halt_pc", {28'd0, bus.imem_addr}, 32'd1);
    chk("wrap_sb_drained", exp_q.size(), 32'd0);

    // Reset asserted during WB of an ADD, then re-run from address 0
    setup(4'h0, 4'h5, 4'h3, 4'h0, 8'hFF);
    rom[0] = 8'b010_01_10_0;
    do_reset();
    start_prog(t0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstwb_rf_rw", {31'd0, bus.rf_rw}, 32'd1);
    chk("rstwb_dm_rw", {31'd0, bus.dm_rw}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("rstwb_pc", {28'd0, bus.imem_addr}, 32'd0);
    chk("rstwb_retired", {24'd0, bus.retired}, 32'd0);
    chk("rstwb_busy", {31'd0, bus.busy}, 32'd0);
    chk("rstwb_sb_drained", exp_q.size(), 32'd0);
    start_prog(t0);
    exp_q.push_back('{1'b0, 4'd1, 4'd8, t0 + 3});
    wait_pc(1, 20, at);
    chk("rerun_latency", at - t0, 32'd4);
    wait_halt(20);
    chk("rerun_retired", {24'd0, bus.retired}, 32'd1);
    chk("rerun_sb_drained", exp_q.size(), 32'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
